// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the processor ports, the arbiter and the memory.
// The slave modport is the arbiter's view; master is the environment side.
interface mem_port_arbiter_if #(
  parameter int unsigned BUS_WIDTH = 32
);
  logic                 m0_req;
  logic [BUS_WIDTH-1:0] m0_addr;
  logic                 m0_ack;
  logic [BUS_WIDTH-1:0] m0_rdata;
  logic                 m1_req;
  logic                 m1_we;
  logic [BUS_WIDTH-1:0] m1_addr;
  logic [BUS_WIDTH-1:0] m1_wdata;
  logic                 m1_ack;
  logic [BUS_WIDTH-1:0] m1_rdata;
  logic                 mem_en;
  logic                 mem_we;
  logic [BUS_WIDTH-1:0] mem_addr;
  logic [BUS_WIDTH-1:0] mem_wdata;
  logic [BUS_WIDTH-1:0] mem_rdata;
  logic                 mem_ready;
  logic [BUS_WIDTH-1:0] mem_map_io;
  logic                 bus_err;

  modport slave (
    input  m0_req, m0_addr, m1_req, m1_we, m1_addr, m1_wdata, mem_rdata, mem_ready,
    output m0_ack, m0_rdata, m1_ack, m1_rdata, mem_en, mem_we, mem_addr, mem_wdata,
           mem_map_io, bus_err
  );

  modport master (
    output m0_req, m0_addr, m1_req, m1_we, m1_addr, m1_wdata, mem_rdata, mem_ready,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata, mem_en, mem_we, mem_addr, mem_wdata,
           mem_map_io, bus_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory between fetch (m0) and data (m1) ports,
// with one memory-mapped IO word. Define MEM_TIMEOUT_EN for the BUSY-state abort.
module mem_port_arbiter #(
  parameter int unsigned          BUS_WIDTH      = 32,
  parameter logic [BUS_WIDTH-1:0] IO_ADDR        = 32'hFFFF_FFFC,
  parameter int unsigned          TIMEOUT_CYCLES = 16
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_IO   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0]           state;
  logic                 gnt_m1;
  logic                 last_m0;   // 0 after reset means "m1 last", so m0 wins the first tie
  logic                 lat_we;
  logic [BUS_WIDTH-1:0] lat_addr;
  logic [BUS_WIDTH-1:0] lat_wdata;
  logic [BUS_WIDTH-1:0] io_reg;
  logic [BUS_WIDTH-1:0] m0_rdata_q;
  logic [BUS_WIDTH-1:0] m1_rdata_q;
  logic                 pick_m1;

  assign pick_m1 = bus.m1_req && (!bus.m0_req || last_m0);

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt;
  logic             err_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      gnt_m1     <= 1'b0;
      last_m0    <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      io_reg     <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
`ifdef MEM_TIMEOUT_EN
      to_cnt     <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.m0_req || bus.m1_req) begin
            gnt_m1    <= pick_m1;
            lat_we    <= pick_m1 ? bus.m1_we : 1'b0;
            lat_addr  <= pick_m1 ? bus.m1_addr : bus.m0_addr;
            lat_wdata <= pick_m1 ? bus.m1_wdata : '0;
            state     <= (pick_m1 && bus.m1_addr == IO_ADDR) ? S_IO : S_BUSY;
`ifdef MEM_TIMEOUT_EN
            to_cnt    <= '0;
            err_q     <= 1'b0;
`endif
          end
        end
        S_BUSY: begin
          if (bus.mem_ready) begin
            if (!gnt_m1)     m0_rdata_q <= bus.mem_rdata;
            else if (!lat_we) m1_rdata_q <= bus.mem_rdata;
            state <= S_RESP;
          end
`ifdef MEM_TIMEOUT_EN
          else if (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            if (!gnt_m1)     m0_rdata_q <= BUS_WIDTH'(32'hDEAD_BEEF);
            else if (!lat_we) m1_rdata_q <= BUS_WIDTH'(32'hDEAD_BEEF);
            err_q <= 1'b1;
            state <= S_RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        S_IO: begin
          if (lat_we) io_reg     <= lat_wdata;
          else        m1_rdata_q <= io_reg;
          state <= S_RESP;
        end
        default: begin
          last_m0 <= !gnt_m1;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  // Memory strobes decode directly from state so reset drops mem_en without a clock.
  assign bus.mem_en     = (state == S_BUSY);
  assign bus.mem_we     = (state == S_BUSY) && lat_we;
  assign bus.mem_addr   = lat_addr;
  assign bus.mem_wdata  = lat_wdata;
  assign bus.m0_ack     = (state == S_RESP) && !gnt_m1;
  assign bus.m1_ack     = (state == S_RESP) && gnt_m1;
  assign bus.m0_rdata   = m0_rdata_q;
  assign bus.m1_rdata   = m1_rdata_q;
  assign bus.mem_map_io = io_reg;
`ifdef MEM_TIMEOUT_EN
  assign bus.bus_err    = (state == S_RESP) && err_q;
`else
  assign bus.bus_err    = 1'b0;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the multi-cycle processor's instruction-fetch port (m0, read-only) and data port (m1, read/write).
- Round-robin arbitration with a per-requester req/ack handshake.
- Decodes one memory-mapped IO word at IO_ADDR. This word drives the board-level mem_map_io output, whose bits [7:0] go to the LEDs.
- Sits between the processor and the memory/IO in the top level.

Parameters:
- BUS_WIDTH, 32, data and address width in bits.
- IO_ADDR, 32'hFFFF_FFFC, word address decoded as the IO register (m1 only).
- TIMEOUT_CYCLES, 16, maximum cycles spent in BUSY before abort (used only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- m0_req  in  1  fetch request; held high with m0_addr stable until m0_ack.
- m0_addr  in  BUS_WIDTH  fetch address.
- m0_ack  out  1  one-cycle pulse; m0_rdata is valid in the same cycle.
- m0_rdata  out  BUS_WIDTH  fetched word.
- m1_req  in  1  data request; held with m1_addr, m1_we and m1_wdata stable until m1_ack.
- m1_we  in  1  1 = write, 0 = read.
- m1_addr  in  BUS_WIDTH  data address.
- m1_wdata  in  BUS_WIDTH  write data.
- m1_ack  out  1  one-cycle pulse; m1_rdata is valid in the same cycle.
- m1_rdata  out  BUS_WIDTH  read data.
- mem_en  out  1  memory access strobe, held until mem_ready.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  BUS_WIDTH  memory address.
- mem_wdata  out  BUS_WIDTH  memory write data.
- mem_rdata  in  BUS_WIDTH  memory read data, valid when mem_ready=1.
- mem_ready  in  1  memory completion, sampled only in BUSY.
- mem_map_io  out  BUS_WIDTH  IO register contents.
- bus_err  out  1  one-cycle pulse accompanying an aborted ack.

Behaviour:
- Reset (asynchronous, active-high) clears the following to 0: state, all outputs, IO register, last-grant flag. The last-grant flag is cleared to "m1", so m0 wins the first tie.
- States:
  - IDLE: no request → stay in IDLE.
  - IDLE, requests present → grant by round-robin:
    - If both requesters are high, grant the one not granted last.
    - If only one is high, grant it.
  - IDLE, m1 granted with m1_addr == IO_ADDR → go to IO.
  - IDLE, any other grant → go to BUSY. Latch the grant and the request fields into registers.
  - BUSY:
    - mem_en=1, mem_we = latched we (0 for m0); mem_addr and mem_wdata come from the latched fields.
    - On mem_ready=1: capture mem_rdata and go to RESP. mem_en drops on the next cycle.
  - IO:
    - Write: the IO register takes the latched wdata.
    - Read: capture the IO register as rdata.
    - No memory access (mem_en stays 0). Go to RESP.
  - RESP:
    - Pulse the granted requester's ack for one cycle, with rdata registered.
    - Update the last-grant flag. Go to IDLE.
- Latency, request high in cycle 0 (in IDLE):
  - Memory access: BUSY in cycle 1; with mem_ready in cycle 1, ack in cycle 2. Each extra wait cycle adds 1.
  - IO access: ack in cycle 2.
- Throughput: at most one transaction per 3 cycles.
- Back-to-back: after an ack, the requester may lower req or present a new request in the next cycle. The arbiter re-arbitrates in IDLE, and ack is never issued twice for one request.
- Request dropped mid-transaction: the transaction still completes and ack is still pulsed. The requester must ignore it.
- rdata outputs hold their last value between acks; they are 0 after reset. On a write ack, m1_rdata is unchanged.
- The IO register is reachable only from m1; an m0 fetch of IO_ADDR goes to memory.
- Reset in BUSY: mem_en drops immediately and no ack is issued.
- The IO register updates exactly once per IO write, in the IO state.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A counter runs in BUSY and clears on entry to BUSY.
  - If mem_ready is not seen within TIMEOUT_CYCLES cycles, abort to RESP with rdata = 32'hDEAD_BEEF.
  - bus_err pulses with the ack.
  - mem_en drops on the abort.
- MEM_TIMEOUT_EN undefined:
  - No counter; BUSY waits indefinitely.
  - bus_err is tied to 0.

Test Plan:
- Single fetch: m0_req, addr 0x10; memory returns 0x00500093 with mem_ready in the first BUSY cycle → m0_ack in cycle 2 with m0_rdata=0x00500093; mem_en high exactly 1 cycle.
- Simultaneous m0 and m1 read right after reset, both held → m0 served first, then m1; alternate continuously thereafter. No ack overlap; each ack is exactly 1 cycle.
- IO write: m1 write to IO_ADDR with 0x000000A5 → mem_map_io=0x000000A5 by the ack cycle, mem_en never asserted. A following m1 read of IO_ADDR returns 0x000000A5.
- Wait states: mem_ready delayed 3 cycles on an m1 write to 0x20 with data 0x12345678 → mem_en, mem_we, mem_addr and mem_wdata stable for 4 cycles; ack in cycle 5.
- Reset asserted during BUSY → mem_en=0 and the IO register is 0 asynchronously; no ack issued; a fresh request after release completes normally.
- With MEM_TIMEOUT_EN, mem_ready held at 0 → ack and bus_err pulse after 16 BUSY cycles with rdata=0xDEADBEEF. Without the macro, still waiting at cycle 100.
